// File: rtl/meas_window_ctrl.sv
// ---------------------------------------------------------------------------
// meas_window_ctrl
//   Sequences an external up_counter as a gated event counter. A start request
//   clears the counter, then gates it with the event strobe for exactly
//   WINDOW_LEN clock cycles. After that the count and a sticky wrap flag are
//   latched into a result register, which is offered on a valid/ready port.
//
//   Optional feature macro: MEAS_CONTINUOUS_EN
//     defined   - after a result handshake the next window starts immediately
//     undefined - after a result handshake the block returns to IDLE
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   measurement request, only looked at in IDLE
//   abort      in   cancel the measurement in progress (beats start/res_ready)
//   event_i    in   synchronous single-cycle event strobe
//   cnt_i      in   current value of the external counter
//   cnt_clk_en out  clock enable for the external counter
//   cnt_clear  out  synchronous clear for the external counter
//   res_valid  out  res_data / res_ovf hold a result
//   res_ready  in   consumer accepts the result
//   res_data   out  latched event count
//   res_ovf    out  counter wrapped at least once during the window
//   busy       out  FSM is not in IDLE
// ---------------------------------------------------------------------------
module meas_window_ctrl #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 24,
    parameter int WINDOW_LEN = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             event_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             cnt_clk_en,
    output logic             cnt_clear,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    localparam longint WIN_MAX = (64'sd1 <<< WIN_W) - 64'sd1;

    // Reject a window length that cannot be counted by the timer.
    if ((WINDOW_LEN < 2) || (longint'(WINDOW_LEN) > WIN_MAX)) begin : g_bad_window
        $error("meas_window_ctrl: WINDOW_LEN out of range 2..2**WIN_W-1");
    end

    // Timer counts WINDOW_LEN-1 down to 0, giving WINDOW_LEN GATE cycles.
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_GATE  = 3'd2,
        S_LATCH = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIN_W-1:0] timer_r;
    logic             sticky_r;
    logic             res_valid_r;
    logic [CNT_W-1:0] res_data_r;
    logic             res_ovf_r;
    logic             cnt_clk_en_s;
    logic             cnt_clear_s;
    logic             abort_hit_s;

    // Abort only has an effect once a measurement is under way.
    assign abort_hit_s = abort && (state_r != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; abort has priority over every other request.
    always_comb begin
        next_state_s = state_r;
        if (abort_hit_s) begin
            next_state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start && !abort) begin
                        next_state_s = S_CLEAR;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end
                S_CLEAR: next_state_s = S_GATE;
                S_GATE: begin
                    if (timer_r == WIN_ZERO) begin
                        next_state_s = S_LATCH;
                    end else begin
                        next_state_s = S_GATE;
                    end
                end
                S_LATCH: next_state_s = S_HOLD;
                S_HOLD: begin
                    if (res_ready) begin
`ifdef MEAS_CONTINUOUS_EN
                        next_state_s = S_CLEAR;
`else
                        next_state_s = S_IDLE;
`endif
                    end else begin
                        next_state_s = S_HOLD;
                    end
                end
                default: next_state_s = S_IDLE;
            endcase
        end
    end

    // Counter control decode; the counter honours clear only while enabled.
    always_comb begin
        cnt_clk_en_s = 1'b0;
        cnt_clear_s  = 1'b0;
        case (state_r)
            S_CLEAR: begin
                cnt_clk_en_s = 1'b1;
                cnt_clear_s  = 1'b1;
            end
            S_GATE: begin
                cnt_clk_en_s = event_i;
                cnt_clear_s  = 1'b0;
            end
            default: begin
                cnt_clk_en_s = 1'b0;
                cnt_clear_s  = 1'b0;
            end
        endcase
    end

    // Window timer and sticky wrap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r  <= WIN_ZERO;
            sticky_r <= 1'b0;
        end else begin
            case (state_r)
                S_CLEAR: begin
                    timer_r  <= WIN_LOAD;
                    sticky_r <= 1'b0;
                end
                S_GATE: begin
                    if (timer_r != WIN_ZERO) begin
                        timer_r <= timer_r - WIN_ONE;
                    end
                    // An event seen while the counter is all ones wraps it to zero.
                    if (event_i && (&cnt_i)) begin
                        sticky_r <= 1'b1;
                    end
                end
                default: begin
                    timer_r  <= timer_r;
                    sticky_r <= sticky_r;
                end
            endcase
        end
    end

    // Result register and valid flag; abort drops valid but keeps old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_data_r  <= {CNT_W{1'b0}};
            res_ovf_r   <= 1'b0;
        end else if (abort_hit_s) begin
            res_valid_r <= 1'b0;
        end else if (state_r == S_LATCH) begin
            res_valid_r <= 1'b1;
            res_data_r  <= cnt_i;
            res_ovf_r   <= sticky_r;
        end else if ((state_r == S_HOLD) && res_ready) begin
            res_valid_r <= 1'b0;
        end
    end

    assign cnt_clk_en = cnt_clk_en_s;
    assign cnt_clear  = cnt_clear_s;
    assign res_valid  = res_valid_r;
    assign res_data   = res_data_r;
    assign res_ovf    = res_ovf_r;
    assign busy       = (state_r != S_IDLE);

endmodule

// File: tb/tb_meas_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_meas_window_ctrl
//   Two instances share one stimulus stream: an 8-bit counter build and a
//   3-bit counter build (to exercise wrap-around), both with a 10-cycle
//   window. Each drives its own behavioural up_counter. Expected results are
//   derived from the window timing: edge k after the start edge is CLEAR for
//   k=1, GATE for k=2..W+1, LATCH for k=W+2 and HOLD afterwards, and the
//   result is the number of GATE events modulo 2**CNT_W.
// ---------------------------------------------------------------------------
module tb_meas_window_ctrl;

    localparam int W = 10;
`ifdef MEAS_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic clk, rst_n, start, abort, event_i, res_ready;

    logic [7:0] cnt8, d8;
    logic       en8, clr8, v8, o8, b8;
    logic [2:0] cnt3, d3;
    logic       en3, clr3, v3, o3, b3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_d8 = 8'd0;
    logic       exp_o8 = 1'b0;
    logic [2:0] exp_d3 = 3'd0;
    logic       exp_o3 = 1'b0;

    meas_window_ctrl #(.CNT_W(8), .WIN_W(24), .WINDOW_LEN(W)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .event_i(event_i),
        .cnt_i(cnt8), .cnt_clk_en(en8), .cnt_clear(clr8), .res_valid(v8),
        .res_ready(res_ready), .res_data(d8), .res_ovf(o8), .busy(b8)
    );

    meas_window_ctrl #(.CNT_W(3), .WIN_W(4), .WINDOW_LEN(W)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .event_i(event_i),
        .cnt_i(cnt3), .cnt_clk_en(en3), .cnt_clear(clr3), .res_valid(v3),
        .res_ready(res_ready), .res_data(d3), .res_ovf(o3), .busy(b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External up_counters: clear wins, both need the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt8 <= 8'd0;
            cnt3 <= 3'd0;
        end else begin
            if (en8) cnt8 <= clr8 ? 8'd0 : cnt8 + 8'd1;
            if (en3) cnt3 <= clr3 ? 3'd0 : cnt3 + 3'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {cnt_clk_en, cnt_clear, busy, res_valid} of both instances.
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check({tag, "_ctl8"}, 32'({en8, clr8, b8, v8}), 32'(exp));
        check({tag, "_ctl3"}, 32'({en3, clr3, b3, v3}), 32'(exp));
    endtask

    task automatic check_res(input string tag);
        check({tag, "_data8"}, 32'(d8), 32'(exp_d8));
        check({tag, "_ovf8"},  32'(o8), 32'(exp_o8));
        check({tag, "_data3"}, 32'(d3), 32'(exp_d3));
        check({tag, "_ovf3"},  32'(o3), 32'(exp_o3));
    endtask

    // One measurement window. mode: 0 random, 1 event always high,
    // 2 events at CLEAR/first GATE/last GATE/LATCH/HOLD, 3 seven spread events.
    // abort_k: edge index at which abort is applied (0 = never).
    task automatic run_window(input int hold, input int mode, input bit do_start, input int abort_k);
        int  n_ev;
        bit  ev, gate, hold_ph;
        n_ev = 0;
        if (do_start) begin
            start     = 1'b1;
            abort     = 1'b0;
            event_i   = 1'($urandom_range(1, 0));
            res_ready = 1'($urandom_range(1, 0));
            #1;
            check_ctl("idle", 4'b0000);
            @(posedge clk); #1;
        end
        for (int k = 1; k <= W + 3 + hold; k++) begin
            gate    = (k >= 2) && (k <= W + 1);
            hold_ph = (k >= W + 3);
            case (mode)
                1:       ev = 1'b1;
                2:       ev = (k == 1) || (k == 2) || (k == W + 1) || (k == W + 2) || (k == W + 3);
                3:       ev = (k == 2) || (k == 3) || (k == 5) || (k == 7) || (k == 8) ||
                              (k == 10) || (k == 11);
                default: ev = ($urandom_range(99, 0) < 50);
            endcase
            event_i   = ev;
            start     = 1'($urandom_range(1, 0));
            abort     = (k == abort_k);
            res_ready = hold_ph ? (k == W + 3 + hold) : 1'($urandom_range(1, 0));
            if (k == abort_k) begin
                start     = 1'b1;
                res_ready = 1'b1;
            end
            #1;
            check_ctl($sformatf("k%0d", k),
                      {(k == 1) ? 1'b1 : (gate ? ev : 1'b0), (k == 1), 1'b1, hold_ph});
            if (hold_ph) check_res($sformatf("hold_k%0d", k));
            if (gate && ev) n_ev++;
            @(posedge clk); #1;
            if (k == abort_k) begin
                abort = 1'b0;
                start = 1'b0;
                check_ctl("after_abort", 4'b0000);
                check_res("after_abort");
                return;
            end
            if (k == W + 2) begin
                exp_d8 = 8'(n_ev % 256);
                exp_o8 = (n_ev >= 256);
                exp_d3 = 3'(n_ev % 8);
                exp_o3 = (n_ev >= 8);
            end
        end
        start = 1'b0;
        // After the handshake: IDLE, or a fresh CLEAR in continuous mode.
        check_ctl("post_hs", CONT ? 4'b1110 : 4'b0000);
        check_res("post_hs");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; event_i = 1'b0; res_ready = 1'b0;
        @(posedge clk); #1;
        check_ctl("reset", 4'b0000);
        check_res("reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Seven events: result 7 twelve cycles after start.
        run_window(0, 3, 1'b1, 0);
        check("seven_events", 32'(d8), 32'd7);
        if (CONT) run_window(0, 3, 1'b0, 1);

        // Boundary events: only first and last GATE cycles count.
        run_window(0, 2, 1'b1, 0);
        check("edge_events8", 32'(d8), 32'd2);
        check("edge_events3", 32'(d3), 32'd2);
        if (CONT) run_window(0, 2, 1'b0, 1);

        // Event held high for a full window: 3-bit counter wraps.
        run_window(0, 1, 1'b1, 0);
        check("full_data3", 32'(d3), 32'd2);
        check("full_ovf3",  32'(o3), 32'd1);
        check("full_data8", 32'(d8), 32'd10);
        if (CONT) run_window(0, 1, 1'b0, 1);

        // Consumer stalls 5 cycles in HOLD.
        run_window(5, 0, 1'b1, 0);
        if (CONT) run_window(0, 0, 1'b0, 1);

        // Randomized windows with random stalls.
        for (int i = 0; i < 4; i++) begin
            run_window($urandom_range(3, 0), 0, 1'b1, 0);
            if (CONT) run_window($urandom_range(2, 0), 0, 1'b0, 0);
            if (CONT) run_window(0, 0, 1'b0, 1);
        end

        // Aborts in GATE, LATCH and HOLD.
        run_window(0, 0, 1'b1, 5);
        run_window(0, 0, 1'b1, W + 2);
        run_window(3, 0, 1'b1, W + 4);
        run_window(0, 0, 1'b1, 1);

        // start and abort together in IDLE.
        start = 1'b1; abort = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check_ctl("start_abort_idle", 4'b0000);
        end
        start = 1'b0; abort = 1'b0;

        // Asynchronous reset in the middle of GATE.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            event_i = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
        end
        event_i = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        exp_d8 = 8'd0; exp_o8 = 1'b0; exp_d3 = 3'd0; exp_o3 = 1'b0;
        check_ctl("mid_reset", 4'b0000);
        check_res("mid_reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_ctl("post_reset", 4'b0000);

        // Normal operation after the reset.
        run_window(1, 0, 1'b1, 0);
        if (CONT) run_window(0, 0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
